// File: rtl/cu_stage_decoder.sv
// cu_stage_decoder: samples the falling-edge control fields (opcode/func3/subsra)
// on the rising edge and decodes them into RV32I control signals. The decoded
// bundle moves through the EX, MEM and WB registers. stall and flush insert
// bubbles, and instructions reaching WB are counted in retired.
// Optional build macro CU_ILLEGAL_TRAP_EN: an unknown valid opcode becomes an EX
// bubble and raises illegal for its EX cycle. Without the macro it travels as a
// valid NOP.
module cu_stage_decoder #(
  parameter int unsigned CNT_W       = 32,
  parameter logic [3:0]  ALUOP_COPYB = 4'b1111
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic             subsra,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_valid,
  output logic [3:0]       ex_alu_op,
  output logic             ex_a_pc,
  output logic             ex_b_imm,
  output logic             ex_branch,
  output logic             ex_jump,
  output logic [2:0]       ex_br_cond,
  output logic             mem_valid,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       mem_width,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic [1:0]       wb_sel,
  output logic [CNT_W-1:0] retired,
  output logic             illegal
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  logic       d_valid;
  logic [3:0] d_alu_op;
  logic       d_a_pc;
  logic       d_b_imm;
  logic       d_branch;
  logic       d_jump;
  logic [2:0] d_br_cond;
  logic       d_mem_read;
  logic       d_mem_write;
  logic [2:0] d_width;
  logic       d_reg_write;
  logic [1:0] d_wb_sel;
`ifdef CU_ILLEGAL_TRAP_EN
  logic       d_illegal;
`endif

  // EX-internal fields carried on to MEM/WB
  logic       ex_mem_read;
  logic       ex_mem_write;
  logic [2:0] ex_width;
  logic       ex_reg_write;
  logic [1:0] ex_wb_sel;
  logic       mem_reg_write;
  logic [1:0] mem_wb_sel;

  // Combinational RV32I control decode of the sampled fields
  always_comb begin
    d_valid     = in_valid;
    d_alu_op    = '0;
    d_a_pc      = 1'b0;
    d_b_imm     = 1'b0;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_br_cond   = '0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_width     = '0;
    d_reg_write = 1'b0;
    d_wb_sel    = '0;
`ifdef CU_ILLEGAL_TRAP_EN
    d_illegal   = 1'b0;
`endif
    case (opcode)
      OP_R: begin
        d_alu_op    = {subsra, func3};
        d_reg_write = 1'b1;
      end
      OP_IALU: begin
        d_alu_op    = {subsra & (func3 == 3'b101), func3};
        d_b_imm     = 1'b1;
        d_reg_write = 1'b1;
      end
      OP_LOAD: begin
        d_b_imm     = 1'b1;
        d_mem_read  = 1'b1;
        d_width     = func3;
        d_reg_write = 1'b1;
        d_wb_sel    = 2'b01;
      end
      OP_STORE: begin
        d_b_imm     = 1'b1;
        d_mem_write = 1'b1;
        d_width     = func3;
      end
      OP_BRANCH: begin
        d_a_pc    = 1'b1;
        d_b_imm   = 1'b1;
        d_branch  = 1'b1;
        d_br_cond = func3;
      end
      OP_JAL: begin
        d_a_pc      = 1'b1;
        d_b_imm     = 1'b1;
        d_jump      = 1'b1;
        d_reg_write = 1'b1;
        d_wb_sel    = 2'b10;
      end
      OP_JALR: begin
        d_b_imm     = 1'b1;
        d_jump      = 1'b1;
        d_reg_write = 1'b1;
        d_wb_sel    = 2'b10;
      end
      OP_LUI: begin
        d_alu_op    = ALUOP_COPYB;
        d_b_imm     = 1'b1;
        d_reg_write = 1'b1;
      end
      OP_AUIPC: begin
        d_a_pc      = 1'b1;
        d_b_imm     = 1'b1;
        d_reg_write = 1'b1;
      end
      default: begin
`ifdef CU_ILLEGAL_TRAP_EN
        d_illegal = in_valid;
        d_valid   = 1'b0;
`endif
      end
    endcase
  end

  // EX register: flush/stall/invalid slots load a bubble
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= '0;
      ex_a_pc      <= 1'b0;
      ex_b_imm     <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_br_cond   <= '0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_width     <= '0;
      ex_reg_write <= 1'b0;
      ex_wb_sel    <= '0;
    end else if (flush || stall || !d_valid) begin
      ex_valid     <= 1'b0;
      ex_alu_op    <= '0;
      ex_a_pc      <= 1'b0;
      ex_b_imm     <= 1'b0;
      ex_branch    <= 1'b0;
      ex_jump      <= 1'b0;
      ex_br_cond   <= '0;
      ex_mem_read  <= 1'b0;
      ex_mem_write <= 1'b0;
      ex_width     <= '0;
      ex_reg_write <= 1'b0;
      ex_wb_sel    <= '0;
    end else begin
      ex_valid     <= 1'b1;
      ex_alu_op    <= d_alu_op;
      ex_a_pc      <= d_a_pc;
      ex_b_imm     <= d_b_imm;
      ex_branch    <= d_branch;
      ex_jump      <= d_jump;
      ex_br_cond   <= d_br_cond;
      ex_mem_read  <= d_mem_read;
      ex_mem_write <= d_mem_write;
      ex_width     <= d_width;
      ex_reg_write <= d_reg_write;
      ex_wb_sel    <= d_wb_sel;
    end
  end

  // MEM register: keeps memory fields plus write-back fields; flush kills it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset || flush) begin
      mem_valid     <= 1'b0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_width     <= '0;
      mem_reg_write <= 1'b0;
      mem_wb_sel    <= '0;
    end else begin
      mem_valid     <= ex_valid;
      mem_read      <= ex_mem_read;
      mem_write     <= ex_mem_write;
      mem_width     <= ex_width;
      mem_reg_write <= ex_reg_write;
      mem_wb_sel    <= ex_wb_sel;
    end
  end

  // WB register: always advances from MEM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_sel       <= '0;
    end else begin
      wb_valid     <= mem_valid;
      wb_reg_write <= mem_reg_write;
      wb_sel       <= mem_wb_sel;
    end
  end

  // Retired counter: counts the WB-valid value seen before each edge, wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= '0;
    end else if (wb_valid) begin
      retired <= retired + CNT_W'(1);
    end
  end

`ifdef CU_ILLEGAL_TRAP_EN
  // Illegal flag occupies the EX slot the trapped instruction would have used
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal <= 1'b0;
    end else begin
      illegal <= d_illegal & ~stall & ~flush;
    end
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
